// File: rtl/nibble_deserializer.sv
// Serial-to-nibble deserializer feeding the 4-input decode stage.
// Holds each nibble under valid/ready and counts transfers the decode stage flags as hits.
module nibble_deserializer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             sync,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             nib_valid,
    input  logic             nib_ready,
    input  logic             l_in,
    output logic [CNT_W-1:0] hit_count,
    output logic             overrun
);

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SH_W  = NIB_W - 1;
    localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {C0, C1, C2, C3} col_state_t;
    typedef enum logic {EMPTY, FULL} out_state_t;

    col_state_t        col_state, col_next;
    out_state_t        out_state, out_next;
    logic [SH_W-1:0]   sh, sh_next;
    logic [NIB_W-1:0]  nib, nib_next;
    logic [CNT_W-1:0]  hit_next;
    logic              overrun_next;
    logic              complete;
    logic              xfer;
    logic              load;
    logic [NIB_W-1:0]  nibble;

    // State registers
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            col_state <= C0;
            out_state <= EMPTY;
            sh        <= '0;
            nib       <= '0;
            hit_count <= '0;
            overrun   <= 1'b0;
        end else begin
            col_state <= col_next;
            out_state <= out_next;
            sh        <= sh_next;
            nib       <= nib_next;
            hit_count <= hit_next;
            overrun   <= overrun_next;
        end
    end

    // Next-state logic for collection, output register and hit counter
    always_comb begin
        col_next     = col_state;
        out_next     = out_state;
        sh_next      = sh;
        nib_next     = nib;
        hit_next     = hit_count;
        overrun_next = overrun;
        complete     = 1'b0;
        xfer         = 1'b0;
        load         = 1'b0;
        nibble       = {sh, serial_in};

        // sync discards any partial nibble; a coincident bit starts the new one
        if (sync) begin
            if (bit_valid) begin
                sh_next  = {{(SH_W-1){1'b0}}, serial_in};
                col_next = C1;
            end else begin
                col_next = C0;
            end
        end else if (bit_valid) begin
            case (col_state)
                C0: begin
                    sh_next  = {sh[SH_W-2:0], serial_in};
                    col_next = C1;
                end
                C1: begin
                    sh_next  = {sh[SH_W-2:0], serial_in};
                    col_next = C2;
                end
                C2: begin
                    sh_next  = {sh[SH_W-2:0], serial_in};
                    col_next = C3;
                end
                C3: begin
                    complete = 1'b1;
                    col_next = C0;
                end
                default: col_next = C0;
            endcase
        end

        xfer = (out_state == FULL) && nib_ready;
        load = complete && ((out_state == EMPTY) || xfer);

        if (load) begin
            nib_next = nibble;
            out_next = FULL;
        end else if (xfer) begin
            out_next = EMPTY;
        end

        if (complete && !load) begin
            overrun_next = 1'b1;
        end

        if (xfer && l_in && (hit_count != HIT_MAX)) begin
            hit_next = hit_count + CNT_W'(1);
        end
    end

    assign a         = nib[3];
    assign b         = nib[2];
    assign c         = nib[1];
    assign d         = nib[0];
    assign nib_valid = (out_state == FULL);

endmodule

// File: doc/nibble_deserializer.md
Name: nibble_deserializer

Overview:
Upstream feeder for the 4-input combinational decode stage. Assembles a serial bit stream into 4-bit nibbles and presents them as a, b, c, d, with a being the first bit received. Each nibble is held under a valid/ready handshake. On each accepted transfer the block samples the decode stage's 1-bit result and counts hits.

Parameters:
CNT_W  8  width of the saturating hit counter

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_L  input  1  asynchronous, active-low reset
serial_in  input  1  serial data bit, MSB (a) first
bit_valid  input  1  serial_in is valid this cycle
sync  input  1  frame sync; restarts nibble alignment
a  output  1  nibble bit 3 (first received)
b  output  1  nibble bit 2
c  output  1  nibble bit 1
d  output  1  nibble bit 0 (last received)
nib_valid  output  1  a..d hold a complete nibble
nib_ready  input  1  downstream accepts the nibble this cycle
l_in  input  1  decode-stage result for the current a..d (combinational, same cycle)
hit_count  output  CNT_W  number of accepted nibbles with l_in==1, saturating
overrun  output  1  sticky; a completed nibble was dropped

Behaviour:
- Reset (reset_L low, asynchronous): a, b, c, d, nib_valid, hit_count and overrun all go to 0. The internal shift register and bit counter also clear.
- Collect FSM (bit counter, states C0, C1, C2, C3, counting bits held in the shift register):
  - C0->C1, C1->C2, C2->C3: on bit_valid, shift serial_in into the 3-bit shift register.
  - C3 + bit_valid: the nibble completes as {sh[2], sh[1], sh[0], serial_in}, so the first bit becomes a. The FSM returns to C0.
  - No bit_valid: hold state.
- sync:
  - When sync=1, any partial nibble is discarded.
  - If bit_valid=1 in the same cycle, that bit is taken as the first bit and the next state is C1. Otherwise the next state is C0.
  - sync never affects the output register, nib_valid or hit_count.
  - sync in C3 together with bit_valid does not complete a nibble.
- Output register, states EMPTY (nib_valid=0) and FULL (nib_valid=1):
  - Transfer occurs on a cycle with nib_valid && nib_ready.
  - A completed nibble loads into a..d if the register is EMPTY, or if it is FULL and a transfer occurs that same cycle. nib_valid is then 1 after the edge.
  - A completed nibble that arrives when the register is FULL with no transfer is dropped. a..d stay unchanged and overrun is set to 1, where it remains until reset.
  - A transfer with no new nibble moves the register to EMPTY. a..d keep their last value (don't-care to downstream).
  - a..d and nib_valid must not change while nib_valid && !nib_ready.
  - nib_valid does not depend combinationally on nib_ready.
- Latency: when the 4th bit is sampled at edge k, nib_valid=1 and a..d are valid from edge k until the transfer. The best-case rate is one nibble per 4 bit_valid cycles with no stalls required.
- Hit counting:
  - On each transfer with l_in==1, hit_count increments by 1.
  - At 2^CNT_W-1 it holds (saturates, no wrap).
  - l_in is ignored when no transfer occurs.
- bit_valid gaps of any length between bits are allowed; state is held across them.

Test Plan:
- Basic assembly: reset, nib_ready=1, then bits 1,0,1,1 on 4 consecutive cycles -> after 4th edge a=1, b=0, c=1, d=1, nib_valid=1 for one cycle. Bench drives l_in=0 -> hit_count stays 0.
- Gapped input and back-pressure: bits 0,1,0,1 with bit_valid low 2 cycles between each, nib_ready=0 -> nib_valid=1, a..d=0101 held stable for 10 cycles. Then nib_ready=1 with l_in=1 -> nib_valid=0 next edge, hit_count=1.
- Simultaneous load and transfer: nibble 0010 held FULL, then 4th bit of nibble 0110 arrives on the same cycle as nib_ready=1 -> a..d=0110, nib_valid stays 1, overrun=0.
- Overrun: nibble 1111 held with nib_ready=0 while a second nibble 0000 completes -> a..d remain 1111, overrun=1. overrun stays 1 after the later transfer, until reset_L pulses low.
- Sync realignment: bits 1,1 then sync=1 with bit_valid=1, serial_in=0, then bits 1,0,1 -> one nibble a..d=0101. The discarded 1,1 never appears.
- Saturation and reset mid-operation: CNT_W=2, 4 accepted nibbles with l_in=1 -> hit_count=3 (held). Assert reset_L low mid-nibble with nib_valid=1 -> nib_valid, a..d, hit_count and overrun=0 immediately, without waiting for a clock edge.
